// File: rtl/full_adder_core.sv
// full_adder_core: registered ripple-carry adder built from 1-bit full-adder cells.
// Optional FULL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module full_adder_core #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .i_a(a[i]),
            .i_b(b[i]),
            .i_c(w_c[i]),
            .o_s(w_s[i]),
            .o_c(w_c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_s;
                r_cout <= w_c[WIDTH];
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_out_valid;

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: carry into the sign cell differs from carry out of it.
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else if (in_valid)
            r_ovf <= w_c[WIDTH-1] ^ w_c[WIDTH];
    end

    assign ovf = r_ovf;
`endif
endmodule

// File: tb/tb_full_adder_core.sv
// tb_full_adder_core: scoreboard bench for WIDTH=1 and WIDTH=8 instances.
// ovf is checked only when FULL_ADDER_OVF_EN is defined.
module tb_full_adder_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
    logic       v8 = 1'b0, c8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       sum1, cout1, ov1;
    logic [7:0] sum8;
    logic       cout8, ov8;
    logic       ovf1, ovf8;
    logic [9:0] q1[$];
    logic [9:0] q8[$];
    logic [9:0] e1 = '0, e8 = '0;
    logic       ev1 = 1'b0, ev8 = 1'b0, started = 1'b0;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    full_adder_core #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .sum(sum1), .cout(cout1), .out_valid(ov1)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    full_adder_core #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .sum(sum8), .cout(cout8), .out_valid(ov8)
`ifdef FULL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

`ifndef FULL_ADDER_OVF_EN
    assign ovf1 = 1'b0;
    assign ovf8 = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: results travel through the queues, reset clears, idle holds.
    always @(posedge clk) begin
        started <= 1'b1;
        if (!rst_n) begin
            e1 <= '0; ev1 <= 1'b0;
            e8 <= '0; ev8 <= 1'b0;
        end else begin
            ev1 <= v1;
            ev8 <= v8;
            if (v1) e1 <= (q1.size() > 0) ? q1.pop_front() : 10'bx;
            if (v8) e8 <= (q8.size() > 0) ? q8.pop_front() : 10'bx;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("ov1", ov1, ev1);
            check("sum1", sum1, e1[0]);
            check("cout1", cout1, e1[1]);
            check("ov8", ov8, ev8);
            check("sum8", sum8, e8[7:0]);
            check("cout8", cout8, e8[8]);
`ifdef FULL_ADDER_OVF_EN
            check("ovf1", ovf1, e1[2]);
            check("ovf8", ovf8, e8[9]);
`endif
        end
    end

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        logic [1:0] s;
        @(posedge clk);
        #1;
        v1 = v; a1 = a; b1 = b; c1 = c;
        s = {1'b0, a} + {1'b0, b} + {1'b0, c};
        if (v && rst_n) q1.push_back({(a == b) && (s[0] != a), s});
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] s;
        @(posedge clk);
        #1;
        v8 = v; a8 = a; b8 = b; c8 = c;
        s = {1'b0, a} + {1'b0, b} + {8'd0, c};
        if (v && rst_n) q8.push_back({(a[7] == b[7]) && (s[7] != a[7]), s});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] t;
            t = 3'(i);
            drive1(1'b1, t[2], t[1], t[0]);
        end
        drive1(1'b0, 1'b1, 1'b1, 1'b1);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive8(1'b1, 8'hFF, 8'h01, 1'b0);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        drive8(1'b1, 8'h00, 8'h00, 1'b0);
        drive8(1'b1, 8'h50, 8'h0A, 1'b0);
        drive8(1'b0, 8'h11, 8'h22, 1'b1);
        drive8(1'b0, 8'h33, 8'h44, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        v8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0;
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive8(1'b1, 8'h01, 8'h02, 1'b0);
        drive8(1'b1, 8'h03, 8'h04, 1'b0);
        drive8(1'b1, 8'h80, 8'h80, 1'b0);
        drive8(1'b1, 8'h7F, 8'h00, 1'b1);
        drive8(1'b1, 8'h7F, 8'h01, 1'b0);
        drive8(1'b1, 8'h01, 8'h01, 1'b0);
        drive8(1'b1, 8'hA5, 8'h5A, 1'b1);
        for (int i = 0; i < 20; i++)
            drive8(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        drive1(1'b1, 1'b1, 1'b1, 1'b0);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
